lcd_char_ctrl: RTL and testbench

- Parametrised HD44780-compatible character-LCD controller. Successor to the fixed 16x2 LCD block.
- Supports 1/2/4 rows, any column count, and cycle-count timing parameters.
- Adds a valid/ready character-write interface, a clear command, an init-done flag and out-of-range error reporting.
- Sits between the application logic and the board LCD pins. Write-only bus: RW is always 0.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_bus_cycle.sv | 107 ++++++++++
 rtl/lcd_char_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: command bytes, FSM states, DDRAM row bases.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_1L = 8'h30;
    localparam logic [7:0] FUNC_SET_2L = 8'h38;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] ENTRY_INC   = 8'h06;
    localparam logic [7:0] SET_DDRAM   = 8'h80;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SET_ADDR,
        ST_WR_DATA,
        ST_CLEAR
    } lcd_state_e;

    typedef enum logic [1:0] {
        BP_IDLE,
        BP_SETUP,
        BP_STROBE,
        BP_HOLD
    } bus_phase_e;

    // Rows 2/3 of a 4-line panel continue rows 0/1 past the visible columns.
    function automatic logic [6:0] row_base(input logic [1:0] row, input int cols);
        case (row)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'(cols);
            default: return 7'(7'h40 + 7'(cols));
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write: setup with EN low, EN strobe, then post-strobe wait (long for clear).
// Latency: T_AS+T_EN+T_CMD (or T_CLR) cycles from start; o_done is high in the last one.
// No backpressure: a new start is taken when idle or in the o_done cycle, back to back.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC  = 2,
    parameter int T_EN_CYC  = 25,
    parameter int T_CMD_CYC = 2000,
    parameter int T_CLR_CYC = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long_wait,
    output logic [7:0] o_DATA,
    output logic       o_EN,
    output logic       o_RS,
    output logic       o_done
);
    localparam int T_A   = (T_AS_CYC > T_EN_CYC) ? T_AS_CYC : T_EN_CYC;
    localparam int T_B   = (T_CMD_CYC > T_CLR_CYC) ? T_CMD_CYC : T_CLR_CYC;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CNT_W = $clog2(T_MAX + 1);

    bus_phase_e       ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] hold_last;

    assign hold_last = long_q ? CNT_W'(T_CLR_CYC - 1) : CNT_W'(T_CMD_CYC - 1);
    assign o_done    = (ph_q == BP_HOLD) && (cnt_q == hold_last);

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        rs_d   = rs_q;
        en_d   = en_q;
        long_d = long_q;
        case (ph_q)
            BP_SETUP: begin
                if (cnt_q == CNT_W'(T_AS_CYC - 1)) begin
                    ph_d  = BP_STROBE;
                    cnt_d = '0;
                    en_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BP_STROBE: begin
                if (cnt_q == CNT_W'(T_EN_CYC - 1)) begin
                    ph_d  = BP_HOLD;
                    cnt_d = '0;
                    en_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BP_HOLD: begin
                if (o_done) begin
                    ph_d = BP_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A start in the done cycle chains the next byte with no idle gap.
        if (i_start) begin
            ph_d   = BP_SETUP;
            cnt_d  = '0;
            data_d = i_data;
            rs_d   = i_rs;
            en_d   = 1'b0;
            long_d = i_long_wait;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ph_q   <= BP_IDLE;
            cnt_q  <= '0;
            data_q <= '0;
            rs_q   <= 1'b0;
            en_q   <= 1'b0;
            long_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rs_q   <= rs_d;
            en_q   <= en_d;
            long_q <= long_d;
        end
    end

    assign o_DATA = data_q;
    assign o_EN   = en_q;
    assign o_RS   = rs_q;

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780 character-LCD controller: power-on init, positioned character writes, clear.
// Latency: write = 2 bus cycles (1 on a cursor hit with LCD_AUTOINC_EN), clear = 1 long bus cycle.
// Backpressure: o_ready high only in IDLE; requests while low are ignored, not queued.
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int ROWS          = 2,
    parameter int COLS          = 16,
    parameter int T_POWERON_CYC = 750000,
    parameter int T_AS_CYC      = 2,
    parameter int T_EN_CYC      = 25,
    parameter int T_CMD_CYC     = 2000,
    parameter int T_CLR_CYC     = 82000,
    localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW           = $clog2(COLS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [RW-1:0] i_row,
    input  logic [CW-1:0] i_col,
    input  logic [7:0]    i_char,
    input  logic          i_clr,
    output logic          o_ready,
    output logic          o_init_done,
    output logic          o_err,
    output logic [7:0]    o_DATA,
    output logic          o_EN,
    output logic          o_RS,
    output logic          o_RW,
    output logic          o_ON,
    output logic          o_BLON
);
    localparam int          PW     = $clog2(T_POWERON_CYC + 1);
    localparam logic [RW:0] ROWS_L = ROWS[RW:0];
    localparam logic [CW:0] COLS_L = COLS[CW:0];

    lcd_state_e    state_q, state_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          init_done_q, init_done_d;
    logic          on_q, on_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    char_q, char_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;

    logic          bus_start, bus_rs, bus_long, bus_done;
    logic [7:0]    bus_data;
    logic          req_bad;
    logic [6:0]    addr;

`ifdef LCD_AUTOINC_EN
    logic          cur_vld_q, cur_vld_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [CW:0]   col_nxt;
    logic          cur_hit;

    assign col_nxt = {1'b0, i_col} + {{CW{1'b0}}, 1'b1};
    assign cur_hit = cur_vld_q && (i_row == cur_row_q) && (i_col == cur_col_q);
`endif

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return (ROWS > 1) ? FUNC_SET_2L : FUNC_SET_1L;
            2'd1:    return DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return ENTRY_INC;
        endcase
    endfunction

    assign req_bad  = ({1'b0, i_row} >= ROWS_L) || ({1'b0, i_col} >= COLS_L);
    assign addr     = row_base(2'(i_row), COLS) + 7'(i_col);
    assign bus_long = !bus_rs && (bus_data == CMD_CLEAR);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        err_d       = 1'b0;
        init_done_d = init_done_q;
        on_d        = 1'b1;
        idx_d       = idx_q;
        char_d      = char_q;
        pwr_cnt_d   = pwr_cnt_q;
        bus_start   = 1'b0;
        bus_rs      = 1'b0;
        bus_data    = 8'h00;
`ifdef LCD_AUTOINC_EN
        cur_vld_d   = cur_vld_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
`endif
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_cnt_q == PW'(T_POWERON_CYC - 1)) begin
                    state_d   = ST_INIT;
                    idx_d     = 2'd0;
                    bus_start = 1'b1;
                    bus_data  = init_byte(2'd0);
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end
            ST_INIT: begin
                if (bus_done) begin
                    if (idx_q == 2'd3) begin
                        state_d     = ST_IDLE;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
`ifdef LCD_AUTOINC_EN
                        cur_vld_d   = 1'b1;
                        cur_row_d   = '0;
                        cur_col_d   = '0;
`endif
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        bus_start = 1'b1;
                        bus_data  = init_byte(idx_q + 2'd1);
                    end
                end
            end
            ST_IDLE: begin
                // ready_q low here only in the cycle after a dropped request.
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else if (i_clr) begin
                    state_d   = ST_CLEAR;
                    ready_d   = 1'b0;
                    bus_start = 1'b1;
                    bus_data  = CMD_CLEAR;
                end else if (i_valid) begin
                    ready_d = 1'b0;
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        char_d    = i_char;
                        bus_start = 1'b1;
                        state_d   = ST_SET_ADDR;
                        bus_data  = SET_DDRAM | {1'b0, addr};
`ifdef LCD_AUTOINC_EN
                        cur_row_d = i_row;
                        cur_col_d = col_nxt[CW-1:0];
                        cur_vld_d = (col_nxt != COLS_L);
                        if (cur_hit) begin
                            state_d  = ST_WR_DATA;
                            bus_rs   = 1'b1;
                            bus_data = i_char;
                        end
`endif
                    end
                end
            end
            ST_SET_ADDR: begin
                if (bus_done) begin
                    state_d   = ST_WR_DATA;
                    bus_start = 1'b1;
                    bus_rs    = 1'b1;
                    bus_data  = char_q;
                end
            end
            ST_WR_DATA: begin
                if (bus_done) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (bus_done) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
`ifdef LCD_AUTOINC_EN
                    cur_vld_d = 1'b1;
                    cur_row_d = '0;
                    cur_col_d = '0;
`endif
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_PWR_WAIT;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
            on_q        <= 1'b0;
            idx_q       <= 2'd0;
            char_q      <= 8'h00;
            pwr_cnt_q   <= '0;
`ifdef LCD_AUTOINC_EN
            cur_vld_q   <= 1'b0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
            on_q        <= on_d;
            idx_q       <= idx_d;
            char_q      <= char_d;
            pwr_cnt_q   <= pwr_cnt_d;
`ifdef LCD_AUTOINC_EN
            cur_vld_q   <= cur_vld_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
`endif
        end
    end

    lcd_bus_cycle #(
        .T_AS_CYC  (T_AS_CYC),
        .T_EN_CYC  (T_EN_CYC),
        .T_CMD_CYC (T_CMD_CYC),
        .T_CLR_CYC (T_CLR_CYC)
    ) u_bus (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (bus_start),
        .i_rs        (bus_rs),
        .i_data      (bus_data),
        .i_long_wait (bus_long),
        .o_DATA      (o_DATA),
        .o_EN        (o_EN),
        .o_RS        (o_RS),
        .o_done      (bus_done)
    );

    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;
    assign o_err       = err_q;
    assign o_ON        = on_q;
    assign o_BLON      = on_q;
    assign o_RW        = 1'b0;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl; a second instance (1 row, 12 cols) exercises out-of-range drops.
module tb_lcd_char_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid = 1'b0, clr = 1'b0;
    logic [0:0] row = '0;
    logic [3:0] col = '0;
    logic [7:0] chr = '0;
    logic       ready, init_done, err, en, rs, rw, on, blon;
    logic [7:0] data;

    logic       e_valid = 1'b0, e_clr = 1'b0;
    logic [0:0] e_row = '0;
    logic [3:0] e_col = '0;
    logic [7:0] e_chr = '0;
    logic       e_ready, e_init_done, e_err, e_en, e_rs, e_rw, e_on, e_blon;
    logic [7:0] e_data;

    lcd_char_ctrl #(
        .ROWS(2), .COLS(16), .T_POWERON_CYC(100), .T_AS_CYC(2),
        .T_EN_CYC(4), .T_CMD_CYC(10), .T_CLR_CYC(50)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_row(row), .i_col(col),
        .i_char(chr), .i_clr(clr), .o_ready(ready), .o_init_done(init_done),
        .o_err(err), .o_DATA(data), .o_EN(en), .o_RS(rs), .o_RW(rw),
        .o_ON(on), .o_BLON(blon)
    );

    // A 4-bit column port cannot express col=16 at COLS=16, so drops are exercised at COLS=12, ROWS=1.
    lcd_char_ctrl #(
        .ROWS(1), .COLS(12), .T_POWERON_CYC(100), .T_AS_CYC(2),
        .T_EN_CYC(4), .T_CMD_CYC(10), .T_CLR_CYC(50)
    ) u_dut_err (
        .i_clk(clk), .i_rst(rst), .i_valid(e_valid), .i_row(e_row), .i_col(e_col),
        .i_char(e_chr), .i_clr(e_clr), .o_ready(e_ready), .o_init_done(e_init_done),
        .o_err(e_err), .o_DATA(e_data), .o_EN(e_en), .o_RS(e_rs), .o_RW(e_rw),
        .o_ON(e_on), .o_BLON(e_blon)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       en_prev = 1'b0;
    int         wcnt = 0;
    int         e_en_cnt = 0;
    logic [8:0] ev_q[$];
    int         ev_t[$];
    int         wid_q[$];

    always @(negedge clk) begin
        if (en && !en_prev) begin
            ev_q.push_back({rs, data});
            ev_t.push_back(cyc);
            wcnt = 0;
        end
        if (en) wcnt++;
        if (!en && en_prev) wid_q.push_back(wcnt);
        en_prev = en;
        if (e_en) e_en_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] v;
        v = (idx < ev_q.size()) ? ev_q[idx] : 9'h1FF;
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_wid(input string tag, input int idx, input int exp);
        int v;
        v = (idx < wid_q.size()) ? wid_q[idx] : -1;
        check(tag, v, exp);
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_t.delete();
        wid_q.delete();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one request for a single cycle and count cycles with o_ready low afterwards.
    task automatic send(input logic c, input logic v, input logic r, input logic [3:0] cl,
                        input logic [7:0] ch, output int low);
        @(negedge clk);
        clr = c; valid = v; row = r; col = cl; chr = ch;
        @(negedge clk);
        clr = 1'b0; valid = 1'b0;
        low = 0;
        while (!ready && low < 2000) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rel, n, low, low2, t0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_data", data, 0);
        check("rst_ready", ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_on", on, 0);
        check("rst_blon", blon, 0);
        check("rst_err", err, 0);
        check("rst_rw", rw, 0);
        rst = 1'b0;
        rel = cyc;
        clear_log();
        repeat (2) @(negedge clk);
        check("pwr_on", on, 1);
        check("pwr_blon", blon, 1);

        // Init sequence timing and bytes
        wait_init(n);
        check("init_done", init_done, 1);
        check("init_done_cyc", cyc - rel, 204);
        t0 = (ev_t.size() > 0) ? ev_t[0] - rel : -1;
        check("init_first_en", t0, 102);
        check("init_cnt", ev_q.size(), 4);
        check_ev("init_b0", 0, 9'h038);
        check_ev("init_b1", 1, 9'h00C);
        check_ev("init_b2", 2, 9'h001);
        check_ev("init_b3", 3, 9'h006);
        check_wid("init_w0", 0, 4);
        check("init_ready", ready, 1);
        check("err_dut_init", e_init_done, 1);

        // Positioned write (1,3) 'A'
        clear_log();
        send(1'b0, 1'b1, 1'b1, 4'd3, 8'h41, low);
        check("wr_low", low, 32);
        check("wr_cnt", ev_q.size(), 2);
        check_ev("wr_addr", 0, 9'h0C3);
        check_ev("wr_char", 1, 9'h141);
        check_wid("wr_w0", 0, 4);
        check_wid("wr_w1", 1, 4);

        // Sequential writes (0,0)'x', (0,1)'y'
        clear_log();
        send(1'b0, 1'b1, 1'b0, 4'd0, 8'h78, low);
        send(1'b0, 1'b1, 1'b0, 4'd1, 8'h79, low2);
        check("seq_low1", low, 32);
        check_ev("seq_a0", 0, 9'h080);
        check_ev("seq_c0", 1, 9'h178);
`ifdef LCD_AUTOINC_EN
        check("seq_low2", low2, 16);
        check("seq_cnt", ev_q.size(), 3);
        check_ev("seq_c1", 2, 9'h179);
`else
        check("seq_low2", low2, 32);
        check("seq_cnt", ev_q.size(), 4);
        check_ev("seq_a1", 2, 9'h081);
        check_ev("seq_c1", 3, 9'h179);
`endif

        // Clear wins over a coincident write
        clear_log();
        send(1'b1, 1'b1, 1'b0, 4'd5, 8'h55, low);
        check("clr_low", low, 56);
        repeat (5) @(negedge clk);
        check("clr_cnt", ev_q.size(), 1);
        check_ev("clr_b0", 0, 9'h001);

        // Out-of-range drops on the 1x12 instance
        e_en_cnt = 0;
        @(negedge clk);
        e_valid = 1'b1; e_row = 1'b0; e_col = 4'd12; e_chr = 8'h41;
        @(negedge clk);
        e_valid = 1'b0;
        check("col_err", e_err, 1);
        check("col_ready_lo", e_ready, 0);
        @(negedge clk);
        check("col_err_end", e_err, 0);
        check("col_ready_back", e_ready, 1);
        e_valid = 1'b1; e_row = 1'b1; e_col = 4'd0;
        @(negedge clk);
        e_valid = 1'b0;
        check("row_err", e_err, 1);
        @(negedge clk);
        check("row_err_end", e_err, 0);
        check("row_ready_back", e_ready, 1);
        repeat (20) @(negedge clk);
        check("err_no_en", e_en_cnt, 0);

        // Reset during an EN strobe
        @(negedge clk);
        valid = 1'b1; row = 1'b0; col = 4'd0; chr = 8'h5A;
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (!en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_en_seen", en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        check("mid_en_low", en, 0);
        check("mid_init_clr", init_done, 0);
        check("mid_ready", ready, 0);
        @(negedge clk);
        clear_log();
        wait_init(n);
        check("mid_reinit", init_done, 1);
        t0 = (ev_t.size() > 0) ? ev_t[0] - rel : -1;
        check("mid_first_en", t0, 102);
        check("mid_cnt", ev_q.size(), 4);
        check_ev("mid_b0", 0, 9'h038);

        // End of row, then next row: address must be re-issued
        clear_log();
        send(1'b0, 1'b1, 1'b0, 4'd15, 8'h61, low);
        send(1'b0, 1'b1, 1'b1, 4'd0, 8'h62, low2);
        check("eor_cnt", ev_q.size(), 4);
        check_ev("eor_a0", 0, 9'h08F);
        check_ev("eor_c0", 1, 9'h161);
        check_ev("eor_a1", 2, 9'h0C0);
        check_ev("eor_c1", 3, 9'h162);
        check("eor_low2", low2, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
